fetch_stage: RTL
================

# fetch_stage

Instruction fetch stage that drives the instruction word into decode. It owns the PC register and a request/acknowledge port to instruction memory that tolerates variable latency. It holds at most two fetched instructions (output register plus a one-entry skid buffer) and honours decode back-pressure and branch redirects. instr_D[31:21] is the opcode field consumed by the main decoder/ALU-decoder controller.

## Interface
- N, 64, PC/address width
- RESET_PC, 0, PC value loaded on reset
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  N  fetch address (= PC)
- imem_ack  in  1  memory returns imem_rdata this cycle; sampled only while imem_req=1
- imem_rdata  in  32  instruction word
- PCSrc  in  1  redirect request, sampled every cycle
- PCBranch  in  N  redirect target
- stall_D  in  1  decode cannot accept this cycle
- valid_D  out  1  instr_D/pc_D hold a live instruction
- instr_D  out  32  instruction to decode (instr_D[31:21] to controller)
- pc_D  out  N  address of instr_D

## Operation
- Reset: PC=RESET_PC, state=FETCH, valid_D=0, instr_D=0, pc_D=0, skid empty. imem_req is 0 while reset is asserted and 1 in the first cycle after release.
- Handoff occurs at a rising edge when valid_D=1 and stall_D=0.
- Memory protocol: once imem_req rises, imem_req and imem_addr stay stable until the edge where imem_ack=1. Zero-wait ack (ack in the first req cycle) is legal.
- imem_req=1 in FETCH and DROP; imem_req=0 in BLOCK.
- FETCH, ack, no PCSrc: PC<=PC+4.
  - Output free (valid_D=0 or handoff): load output with {imem_rdata, PC}; stay FETCH.
  - Output held (valid_D=1, stall_D=1): write to skid; go BLOCK.
- FETCH, handoff without ack: output loads from skid if full, else valid_D<=0.
- BLOCK: on handoff, output<=skid, skid empties, go FETCH. Next request uses PC (already advanced).
- Redirect (PCSrc=1) has priority over everything except reset:
  - PC<=PCBranch; valid_D<=0; skid emptied; instr_D/pc_D contents don't-care.
  - FETCH with ack the same cycle: data discarded; stay FETCH, next req at PCBranch.
  - FETCH without ack: go DROP.
  - BLOCK: go FETCH.
  - DROP: PC<=newest PCBranch; stay DROP, or go FETCH if ack the same cycle.
- DROP: imem_addr holds the stale address until ack. Returned data is discarded. Go FETCH; PC already holds the target.
- PC arithmetic: modulo 2^N, wraps silently.
- reset mid-operation: immediate return to reset values. An outstanding memory request is abandoned.

## Timing
- Zero-wait memory: first instruction has valid_D=1 in cycle 1 after reset release, pc_D=RESET_PC. Sustained throughput is 1 instruction/cycle with stall_D=0.
- Memory latency L cycles (ack in the L-th req cycle): instruction visible the cycle after ack.
- Redirect: valid_D=0 in the cycle after PCSrc. The first target instruction appears no earlier than 2 cycles after PCSrc (zero-wait, no DROP).
- stall_D held: at most 2 instructions are buffered. imem_req falls the cycle after the skid fills.
- Skid release: the instruction appears on instr_D the cycle after handoff. No bubble in order, no duplication, no loss.

## Test plan
- Reset/stream: zero-wait memory returning addr-derived words, stall_D=0 -> pc_D = 0,4,8,… on consecutive cycles from cycle 1; instr_D matches each address.
- Back-pressure: stall_D=1 for 5 cycles starting when pc_D=8 -> pc_D stays 8 and the skid holds 12. imem_req=0 from the next cycle. On release, pc_D=12 then 16; no gaps or repeats.
- Variable latency: ack after 3 cycles per request -> imem_addr stable while req=1; valid_D pulses once per fetch with addresses 0,4,8.
- Redirect during wait: PCSrc=1 with PCBranch=0x100 while req at 0x20 is pending, ack 2 cycles later -> 0x20 data never reaches decode. The next imem_addr is 0x100, then pc_D=0x100.
- Redirect with same-cycle ack and during BLOCK -> discarded data never valid. valid_D=0 the next cycle; the first valid pc_D is the target.
- Async reset mid-stall with skid full -> valid_D=0 and imem_req=0 immediately. After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, variable-latency imem request port, and an output
// register plus one-entry skid buffer feeding decode, with branch redirect support.
module fetch_stage #(
    parameter int           N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ack,
    input  logic [31:0]  imem_rdata,
    input  logic         PCSrc,
    input  logic [N-1:0] PCBranch,
    input  logic         stall_D,
    output logic         valid_D,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D
);
    // state | meaning
    // FETCH | request outstanding at pc_q; returned data goes to output or skid
    // BLOCK | output and skid both full; no request until decode takes one
    // DROP  | redirected while a request was in flight; its data is swallowed
    typedef enum logic [1:0] {FETCH, BLOCK, DROP} state_t;

    state_t         state_q, state_nx;
    logic [N-1:0]   pc_q, pc_nx;
    logic [N-1:0]   drop_addr_q, drop_addr_nx;
    logic           valid_q, valid_nx;
    logic [31:0]    instr_q, instr_nx;
    logic [N-1:0]   pc_d_q, pc_d_nx;
    logic           skid_valid_q, skid_valid_nx;
    logic [31:0]    skid_instr_q, skid_instr_nx;
    logic [N-1:0]   skid_pc_q, skid_pc_nx;
    logic           ack;
    logic           handoff;

    // Gated by reset so no request is seen while the block is held in reset.
    assign imem_req  = ~reset & (state_q != BLOCK);
    // The abandoned request keeps its address on the bus until it is acknowledged.
    assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign valid_D   = valid_q;
    assign instr_D   = instr_q;
    assign pc_D      = pc_d_q;

    assign ack     = imem_ack & imem_req;
    assign handoff = valid_q & ~stall_D;

    always_comb begin
        state_nx      = state_q;
        pc_nx         = pc_q;
        drop_addr_nx  = drop_addr_q;
        valid_nx      = valid_q;
        instr_nx      = instr_q;
        pc_d_nx       = pc_d_q;
        skid_valid_nx = skid_valid_q;
        skid_instr_nx = skid_instr_q;
        skid_pc_nx    = skid_pc_q;

        unique case (state_q)
            FETCH: begin
                if (PCSrc) begin
                    pc_nx         = PCBranch;
                    valid_nx      = 1'b0;
                    skid_valid_nx = 1'b0;
                    if (!ack) begin
                        state_nx     = DROP;
                        drop_addr_nx = pc_q;
                    end
                end else if (ack) begin
                    pc_nx = pc_q + N'(4);
                    if (!valid_q || handoff) begin
                        valid_nx = 1'b1;
                        instr_nx = imem_rdata;
                        pc_d_nx  = pc_q;
                    end else begin
                        skid_valid_nx = 1'b1;
                        skid_instr_nx = imem_rdata;
                        skid_pc_nx    = pc_q;
                        state_nx      = BLOCK;
                    end
                end else if (handoff) begin
                    if (skid_valid_q) begin
                        instr_nx      = skid_instr_q;
                        pc_d_nx       = skid_pc_q;
                        skid_valid_nx = 1'b0;
                    end else begin
                        valid_nx = 1'b0;
                    end
                end
            end
            BLOCK: begin
                if (PCSrc) begin
                    pc_nx         = PCBranch;
                    valid_nx      = 1'b0;
                    skid_valid_nx = 1'b0;
                    state_nx      = FETCH;
                end else if (handoff) begin
                    instr_nx      = skid_instr_q;
                    pc_d_nx       = skid_pc_q;
                    skid_valid_nx = 1'b0;
                    state_nx      = FETCH;
                end
            end
            DROP: begin
                if (PCSrc) begin
                    pc_nx         = PCBranch;
                    valid_nx      = 1'b0;
                    skid_valid_nx = 1'b0;
                end
                if (ack) begin
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= '0;
            valid_q      <= 1'b0;
            instr_q      <= '0;
            pc_d_q       <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= '0;
            skid_pc_q    <= '0;
        end else begin
            state_q      <= state_nx;
            pc_q         <= pc_nx;
            drop_addr_q  <= drop_addr_nx;
            valid_q      <= valid_nx;
            instr_q      <= instr_nx;
            pc_d_q       <= pc_d_nx;
            skid_valid_q <= skid_valid_nx;
            skid_instr_q <= skid_instr_nx;
            skid_pc_q    <= skid_pc_nx;
        end
    end

endmodule
